// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: MicroMIPS multicycle control FSM with memory watchdog.
// Define MC_CTRL_LINK_EN to enable the jal/jr link states.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] fn,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       InstData,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic       RegInSrc,
    output logic       DRegSel0,
    output logic       DRegSel1,
    output logic       ALUSrcX,
    output logic [1:0] ALUSrcY,
    output logic [3:0] ALUFunc,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic [3:0] state_out,
    output logic       illegal,
    output logic       mem_timeout
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EX_R   = 4'd2;
    localparam logic [3:0] S_WB_R   = 4'd3;
    localparam logic [3:0] S_EX_I   = 4'd4;
    localparam logic [3:0] S_WB_I   = 4'd5;
    localparam logic [3:0] S_ADDR   = 4'd6;
    localparam logic [3:0] S_MEM_RD = 4'd7;
    localparam logic [3:0] S_WB_LW  = 4'd8;
    localparam logic [3:0] S_MEM_WR = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       mem_state, expire;
    logic       is_r, is_i, is_jal, is_jr;
    logic [3:0] r_func, i_func;

    // R-type function field to ALU operation
    always_comb begin
        is_r   = (op == 6'd0);
        r_func = 4'd0;
        case (fn)
            6'd32:   r_func = 4'd0;
            6'd34:   r_func = 4'd1;
            6'd42:   r_func = 4'd2;
            6'd36:   r_func = 4'd3;
            6'd37:   r_func = 4'd4;
            6'd38:   r_func = 4'd5;
            6'd39:   r_func = 4'd6;
            default: is_r   = 1'b0;
        endcase
    end

    // I-type opcode to ALU operation
    always_comb begin
        is_i   = 1'b1;
        i_func = 4'd0;
        case (op)
            6'd8:    i_func = 4'd0;
            6'd10:   i_func = 4'd2;
            6'd12:   i_func = 4'd3;
            6'd13:   i_func = 4'd4;
            6'd14:   i_func = 4'd5;
            6'd15:   i_func = 4'd7;
            default: is_i   = 1'b0;
        endcase
    end

`ifdef MC_CTRL_LINK_EN
    assign is_jal = (op == 6'd3);
    assign is_jr  = (op == 6'd0) && (fn == 6'd8);
`else
    assign is_jal = 1'b0;
    assign is_jr  = 1'b0;
`endif

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);
    assign expire    = mem_state && !mem_ready && (wait_q == WAIT_LAST);

    // Next state, watchdog and output decode; everything drops during reset
    always_comb begin
        state_d   = state_q;
        wait_d    = 4'd0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        InstData  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 2'b00;
        RegInSrc  = 1'b0;
        ALUSrcX   = 1'b0;
        ALUSrcY   = 2'b00;
        ALUFunc   = 4'd0;
        PCSrc     = 2'b00;
        PCWrite   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcY = 2'b11;
                if (is_r)                          state_d = S_EX_R;
                else if (is_i)                     state_d = S_EX_I;
                else if (op == 6'd35 || op == 6'd43) state_d = S_ADDR;
                else if (op == 6'd4 || op == 6'd5) state_d = S_BRANCH;
                else if (op == 6'd2)               state_d = S_JUMP;
                else if (is_jal)                   state_d = S_JAL;
                else if (is_jr)                    state_d = S_JR;
                else begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EX_R: begin
                ALUSrcX = 1'b1;
                ALUSrcY = 2'b01;
                ALUFunc = r_func;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                RegInSrc = 1'b1;
                state_d  = S_FETCH;
            end
            S_EX_I: begin
                ALUSrcX = 1'b1;
                ALUSrcY = 2'b10;
                ALUFunc = i_func;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                RegInSrc = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDR: begin
                ALUSrcX = 1'b1;
                ALUSrcY = 2'b10;
                state_d = (op == 6'd35) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                InstData = 1'b1;
                MemRead  = 1'b1;
                if (mem_ready) state_d = S_WB_LW;
            end
            S_WB_LW: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                InstData = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcX = 1'b1;
                ALUSrcY = 2'b01;
                ALUFunc = 4'd1;
                PCSrc   = 2'b01;
                PCWrite = op[0] ? !zero : zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_CTRL_LINK_EN
            S_JAL: begin
                ALUFunc  = 4'd8;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                RegInSrc = 1'b1;
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCSrc   = 2'b11;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        if (mem_state && !mem_ready) begin
            if (expire) begin
                timeout_d = 1'b1;
                state_d   = S_FETCH;
            end else begin
                wait_d = wait_q + 4'd1;
            end
        end
        if (!reset) begin
            InstData = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 2'b00;
            RegInSrc = 1'b0;
            ALUSrcX  = 1'b0;
            ALUSrcY  = 2'b00;
            ALUFunc  = 4'd0;
            PCSrc    = 2'b00;
            PCWrite  = 1'b0;
        end
    end

    assign DRegSel0    = 1'b0;
    assign DRegSel1    = 1'b0;
    assign state_out   = reset ? state_q : S_FETCH;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;

    // State, wait counter and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream against a
// per-instruction expected-trace model of the control FSM.
module tb_multicycle_ctrl;
    localparam int MAXW = 15;
    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4;
    localparam int C_BR = 5, C_J = 6, C_JAL = 7, C_JR = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, fn;
    logic       zero, mem_ready;
    logic       InstData, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst;
    logic       RegInSrc, DRegSel0, DRegSel1, ALUSrcX;
    logic [1:0] ALUSrcY;
    logic [3:0] ALUFunc;
    logic [1:0] PCSrc;
    logic       PCWrite;
    logic [3:0] state_out;
    logic       illegal, mem_timeout;
    logic [19:0] obs;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic        z;
        logic [3:0]  st;
        logic [19:0] outs;
        logic [1:0]  flags;
    } cyc_t;

    cyc_t plan_q[$];
    int   errs = 0;
    int   checks = 0;
    logic m_ill = 1'b0;
    logic m_tmo = 1'b0;
    logic [5:0] op_pool [16] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd12,
                                 6'd13, 6'd14, 6'd15, 6'd35, 6'd43,
                                 6'd4, 6'd5, 6'd2, 6'd3, 6'd9};
    logic [5:0] fn_pool [8] = '{6'd32, 6'd34, 6'd42, 6'd36, 6'd37,
                                6'd38, 6'd39, 6'd8};

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset(reset), .op(op), .fn(fn), .zero(zero),
        .mem_ready(mem_ready), .InstData(InstData), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .RegInSrc(RegInSrc), .DRegSel0(DRegSel0),
        .DRegSel1(DRegSel1), .ALUSrcX(ALUSrcX), .ALUSrcY(ALUSrcY),
        .ALUFunc(ALUFunc), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .state_out(state_out), .illegal(illegal),
        .mem_timeout(mem_timeout)
    );

    assign obs = {InstData, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                  RegInSrc, DRegSel0, DRegSel1, ALUSrcX, ALUSrcY, ALUFunc,
                  PCSrc, PCWrite};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time,
                     got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [19:0] ov(input int idat, mr, mw, irw, rw,
                                       rdst, rin, xs, ys, fun, pcs, pcw);
        return {idat[0], mr[0], mw[0], irw[0], rw[0], rdst[1:0], rin[0],
                1'b0, 1'b0, xs[0], ys[1:0], fun[3:0], pcs[1:0], pcw[0]};
    endfunction

    function automatic int cls(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'd0) begin
            if (f inside {6'd32, 6'd34, 6'd42, 6'd36, 6'd37, 6'd38, 6'd39})
                return C_R;
`ifdef MC_CTRL_LINK_EN
            if (f == 6'd8) return C_JR;
`endif
            return C_ILL;
        end
        if (o inside {6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15}) return C_I;
        if (o == 6'd35) return C_LW;
        if (o == 6'd43) return C_SW;
        if (o == 6'd4 || o == 6'd5) return C_BR;
        if (o == 6'd2) return C_J;
`ifdef MC_CTRL_LINK_EN
        if (o == 6'd3) return C_JAL;
`endif
        return C_ILL;
    endfunction

    function automatic int r_fun(input logic [5:0] f);
        case (f)
            6'd34: return 1;
            6'd42: return 2;
            6'd36: return 3;
            6'd37: return 4;
            6'd38: return 5;
            6'd39: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic int i_fun(input logic [5:0] o);
        case (o)
            6'd10: return 2;
            6'd12: return 3;
            6'd13: return 4;
            6'd14: return 5;
            6'd15: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic push(input logic [5:0] o, f, input int st,
                        input logic r, zz, input logic [19:0] v);
        cyc_t c;
        c.op = o;
        c.fn = f;
        c.rdy = r;
        c.z = zz;
        c.st = 4'(st);
        c.outs = v;
        c.flags = {m_ill, m_tmo};
        plan_q.push_back(c);
    endtask

    task automatic mem_phase(input logic [5:0] o, f, input int st,
                             input logic [19:0] v, input int w,
                             output logic done);
        if (w >= MAXW) begin
            for (int i = 0; i < MAXW; i++) push(o, f, st, 1'b0, rb(), v);
            m_tmo = 1'b1;
            done = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) push(o, f, st, 1'b0, rb(), v);
            push(o, f, st, 1'b1, rb(), v);
            done = 1'b1;
        end
    endtask

    task automatic plan_instr(input logic [5:0] o, f, input int fw, mw,
                              input logic z);
        logic done;
        logic taken;
        for (int i = 0; i < fw; i++)
            push(o, f, 0, 1'b0, rb(), ov(0,1,0,0,0,0,0,0,0,0,0,0));
        push(o, f, 0, 1'b1, rb(), ov(0,1,0,1,0,0,0,0,0,0,0,1));
        push(o, f, 1, rb(), rb(), ov(0,0,0,0,0,0,0,0,3,0,0,0));
        case (cls(o, f))
            C_R: begin
                push(o, f, 2, rb(), rb(), ov(0,0,0,0,0,0,0,1,1,r_fun(f),0,0));
                push(o, f, 3, rb(), rb(), ov(0,0,0,0,1,1,1,0,0,0,0,0));
            end
            C_I: begin
                push(o, f, 4, rb(), rb(), ov(0,0,0,0,0,0,0,1,2,i_fun(o),0,0));
                push(o, f, 5, rb(), rb(), ov(0,0,0,0,1,0,1,0,0,0,0,0));
            end
            C_LW: begin
                push(o, f, 6, rb(), rb(), ov(0,0,0,0,0,0,0,1,2,0,0,0));
                mem_phase(o, f, 7, ov(1,1,0,0,0,0,0,0,0,0,0,0), mw, done);
                if (done)
                    push(o, f, 8, rb(), rb(), ov(0,0,0,0,1,0,0,0,0,0,0,0));
            end
            C_SW: begin
                push(o, f, 6, rb(), rb(), ov(0,0,0,0,0,0,0,1,2,0,0,0));
                mem_phase(o, f, 9, ov(1,0,1,0,0,0,0,0,0,0,0,0), mw, done);
            end
            C_BR: begin
                taken = (o == 6'd4) ? z : !z;
                push(o, f, 10, rb(), z,
                     ov(0,0,0,0,0,0,0,1,1,1,1,int'(taken)));
            end
            C_J:   push(o, f, 11, rb(), rb(), ov(0,0,0,0,0,0,0,0,0,0,2,1));
            C_JAL: push(o, f, 12, rb(), rb(), ov(0,0,0,0,1,2,1,0,0,8,2,1));
            C_JR:  push(o, f, 13, rb(), rb(), ov(0,0,0,0,0,0,0,0,0,0,3,1));
            default: m_ill = 1'b1;
        endcase
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan_q.size() > 0) begin
            c = plan_q.pop_front();
            op = c.op;
            fn = c.fn;
            mem_ready = c.rdy;
            zero = c.z;
            #1;
            chk("state", 32'(state_out), 32'(c.st));
            chk("outs", 32'(obs), 32'(c.outs));
            chk("flags", 32'({illegal, mem_timeout}), 32'(c.flags));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] o, f;
        reset = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b0;
        op = 6'd0;
        fn = 6'd0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_outs", 32'(obs), 32'd0);
            chk("rst_state", 32'(state_out), 32'd0);
            chk("rst_flags", 32'({illegal, mem_timeout}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        plan_instr(6'd0, 6'd32, 0, 0, 1'b0);
        plan_instr(6'd35, 6'd0, 0, 3, 1'b0);
        plan_instr(6'd4, 6'd0, 0, 0, 1'b1);
        plan_instr(6'd4, 6'd0, 1, 0, 1'b0);
        plan_instr(6'd5, 6'd0, 0, 0, 1'b0);
        plan_instr(6'd3, 6'd0, 0, 0, 1'b0);
        plan_instr(6'd0, 6'd8, 0, 0, 1'b0);
        plan_instr(6'd2, 6'd0, 0, 0, 1'b0);
        plan_instr(6'd43, 6'd0, 0, 15, 1'b0);
        plan_instr(6'd15, 6'd0, 2, 0, 1'b0);
        plan_instr(6'd0, 6'd63, 0, 0, 1'b0);
        run_plan();

        for (int k = 0; k < 80; k++) begin
            o = op_pool[$urandom_range(0, 15)];
            f = fn_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            if ($urandom_range(0, 5) == 0) f = 6'($urandom);
            plan_instr(o, f, $urandom_range(0, 2),
                       ($urandom_range(0, 11) == 0) ? MAXW
                                                    : $urandom_range(0, 4),
                       rb());
        end
        run_plan();

        op = 6'd43;
        fn = 6'd0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw_pre_rst", 32'({state_out, MemWrite}), 32'({4'd9, 1'b1}));
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(obs), 32'd0);
        chk("mid_rst_state", 32'(state_out), 32'd0);
        chk("mid_rst_flags", 32'({illegal, mem_timeout}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("post_rst", 32'(obs), 32'(ov(0,1,0,1,0,0,0,0,0,0,0,1)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
